// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: opcode values and FSM state encoding shared by seq_alu_unit and its bench
package seq_alu_pkg;
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_EQ   = 3'b100;
  localparam logic [2:0] OP_GT   = 3'b101;
  localparam logic [2:0] OP_LT   = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;
  typedef enum logic [1:0] {IDLE, ONE, ITER, DONE} state_t;
endpackage

// File: rtl/seq_alu_muldiv_iter.sv
// seq_alu_muldiv_iter: shared hi/lo register running W shift-add (MUL) or restoring (DIV) steps
module seq_alu_muldiv_iter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         is_div,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);
  localparam int CNT_W = $clog2(W + 1);
  logic             r_run, r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_hi, r_lo, r_b;
  logic [W:0]       w_add, w_sh;
  logic [W-1:0]     w_sub;
  logic             w_ge;
  assign w_add = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_sh  = {r_hi, r_lo[W-1]};
  assign w_ge  = w_sh >= {1'b0, r_b};
  // remainder after a successful subtract is below b, so W bits suffice
  assign w_sub = w_sh[W-1:0] - r_b;
  assign done  = r_run & (r_cnt == CNT_W'(W));
  assign hi    = r_hi;
  assign lo    = r_lo;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run <= 1'b0;
      r_div <= 1'b0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_b   <= '0;
    end else if (start) begin
      r_run <= 1'b1;
      r_div <= is_div;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= a;
      r_b   <= b;
    end else if (done) begin
      r_run <= 1'b0;
    end else if (r_run) begin
      r_cnt <= r_cnt + CNT_W'(1);
      r_hi  <= r_div ? (w_ge ? w_sub : w_sh[W-1:0]) : w_add[W:1];
      r_lo  <= r_div ? {r_lo[W-2:0], w_ge} : {w_add[0], r_lo[W-1:1]};
    end
  end
endmodule

// File: rtl/seq_alu_unit.sv
// seq_alu_unit: handshaked W-bit ALU with iterative MUL/DIV
// SEQ_ALU_SAT_EN: ADD/SUB saturate instead of wrapping
module seq_alu_unit import seq_alu_pkg::*; #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic [W-1:0]   rem,
  output logic           flag,
  output logic           div_zero,
  output logic           busy
);
  state_t         r_state, w_next;
  logic [2:0]     r_op;
  logic [W-1:0]   r_a, r_b, r_rem, w_rem, w_hi, w_lo;
  logic [2*W-1:0] r_result, w_res;
  logic           r_flag, r_dz, w_flag, w_dz, w_accept, w_start, w_done, w_cap;
  logic [W:0]     w_sum, w_diff;
  assign w_accept  = in_valid & in_ready;
  assign w_start   = w_accept & (op == OP_MUL | (op == OP_DIV & b != '0));
  assign w_cap     = r_state == ONE | (r_state == ITER & w_done);
  assign w_sum     = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff    = {1'b0, r_a} - {1'b0, r_b};
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == DONE;
  assign busy      = r_state != IDLE;
  assign result    = r_result;
  assign rem       = r_rem;
  assign flag      = r_flag;
  assign div_zero  = r_dz;
  seq_alu_muldiv_iter #(.W(W)) u_iter (
    .clk(clk), .rst(rst), .start(w_start), .is_div(op == OP_DIV),
    .a(a), .b(b), .done(w_done), .hi(w_hi), .lo(w_lo)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_accept ? (w_start ? ITER : ONE) : IDLE;
      ONE:  w_next = DONE;
      ITER: w_next = w_done ? DONE : ITER;
      DONE: w_next = out_ready ? IDLE : DONE;
    endcase
  end
  always_comb begin
    w_res  = '0;
    w_rem  = '0;
    w_flag = 1'b0;
    w_dz   = 1'b0;
    if (r_state == ITER) begin
      w_res = r_op == OP_DIV ? {{W{1'b0}}, w_lo} : {w_hi, w_lo};
      w_rem = r_op == OP_DIV ? w_hi : '0;
    end else begin
      case (r_op)
        OP_ADD: begin
`ifdef SEQ_ALU_SAT_EN
          w_res[W-1:0] = w_sum[W] ? '1 : w_sum[W-1:0];
`else
          w_res[W:0] = w_sum;
`endif
          w_flag = w_sum[W];
        end
        OP_SUB: begin
`ifdef SEQ_ALU_SAT_EN
          w_res[W-1:0] = w_diff[W] ? '0 : w_diff[W-1:0];
`else
          w_res[W-1:0] = w_diff[W-1:0];
`endif
          w_flag = w_diff[W];
        end
        OP_DIV:          w_dz = 1'b1;
        OP_EQ:           w_flag = r_a == r_b;
        OP_GT:           w_flag = r_a > r_b;
        OP_LT:           w_flag = r_a < r_b;
        OP_MUL, OP_RSVD: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_rem    <= '0;
      r_flag   <= 1'b0;
      r_dz     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op <= op;
        r_a  <= a;
        r_b  <= b;
      end
      if (w_cap) begin
        r_result <= w_res;
        r_rem    <= w_rem;
        r_flag   <= w_flag;
        r_dz     <= w_dz;
      end
    end
  end
endmodule

// File: tb/tb_seq_alu_unit.sv
// tb_seq_alu_unit: directed and random requests checked against an arithmetic reference model
module tb_seq_alu_unit;
  import seq_alu_pkg::*;
  localparam int W = 8;
  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, out_valid, out_ready, flag, div_zero, busy;
  logic [2:0]     op;
  logic [W-1:0]   a, b, rem;
  logic [2*W-1:0] result;
  int             n_vec = 0, n_err = 0;
  typedef struct {
    longint res;
    longint rem;
    bit     flag;
    bit     dz;
    int     lat;
  } exp_t;
  always #5 clk = ~clk;
  seq_alu_unit #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .rem(rem), .flag(flag),
    .div_zero(div_zero), .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [2:0] o, input longint x, input longint y);
    exp_t   e;
    longint mx = (longint'(1) << W) - 1;
    e = '{res: 0, rem: 0, flag: 0, dz: 0, lat: 2};
    case (o)
      OP_ADD: begin
        e.flag = (x + y) > mx;
`ifdef SEQ_ALU_SAT_EN
        e.res = e.flag ? mx : x + y;
`else
        e.res = x + y;
`endif
      end
      OP_SUB: begin
        e.flag = x < y;
`ifdef SEQ_ALU_SAT_EN
        e.res = e.flag ? 0 : x - y;
`else
        e.res = (x - y) & mx;
`endif
      end
      OP_MUL: begin
        e.res = x * y;
        e.lat = W + 2;
      end
      OP_DIV: begin
        if (y == 0) e.dz = 1;
        else begin
          e.res = x / y;
          e.rem = x % y;
          e.lat = W + 2;
        end
      end
      OP_EQ: e.flag = x == y;
      OP_GT: e.flag = x > y;
      OP_LT: e.flag = x < y;
      default: ;
    endcase
    return e;
  endfunction
  task automatic check_out(input string t, input exp_t e);
    chk({t, " result"}, result, e.res);
    chk({t, " rem"}, rem, e.rem);
    chk({t, " flag"}, flag, e.flag);
    chk({t, " div_zero"}, div_zero, e.dz);
    chk({t, " out_valid"}, out_valid, 1);
    chk({t, " in_ready"}, in_ready, 0);
  endtask
  task automatic accept(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready before accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); a = W'($urandom); b = W'($urandom);
  endtask
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input int hold);
    exp_t  e;
    int    n;
    bit    bz;
    string t;
    e = model(o, x, y);
    t = $sformatf("op%0d a=%0d b=%0d", o, x, y);
    accept(o, x, y);
    n = 1;
    bz = 1;
    while (!out_valid && n < 60) begin
      bz &= busy;
      @(posedge clk); #1;
      n++;
    end
    chk({t, " latency"}, n, e.lat);
    chk({t, " busy"}, {bz, busy}, 2'b11);
    check_out(t, e);
    repeat (hold) begin
      @(posedge clk); #1;
      check_out({t, " hold"}, e);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    chk({t, " in_ready after"}, in_ready, 1);
    chk({t, " out_valid after"}, out_valid, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "timeout");
  end
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset outputs", {out_valid, busy, flag, div_zero, result, rem}, '0);
    rst = 1'b0;
    run_op(OP_ADD, 200, 100, 0);
    run_op(OP_SUB, 5, 10, 0);
    run_op(OP_GT, 9, 3, 0);
    run_op(OP_LT, 9, 3, 0);
    run_op(OP_MUL, 255, 255, 0);
    run_op(OP_DIV, 200, 7, 0);
    run_op(OP_DIV, 50, 0, 0);
    run_op(OP_ADD, 255, 255, 5);
    run_op(OP_EQ, 4, 4, 0);
    run_op(OP_RSVD, 77, 33, 0);
    run_op(OP_DIV, 255, 1, 2);
    run_op(OP_MUL, 0, 200, 0);
    for (int i = 0; i < 150; i++) begin
      logic [W-1:0] rb;
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_op(3'($urandom), W'($urandom), rb, $urandom_range(0, 2));
    end
    run_op(OP_ADD, 200, 100, 0);
    accept(OP_MUL, 13, 11);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort in_ready", in_ready, 1);
    chk("abort outputs", {out_valid, busy, flag, div_zero, result, rem}, '0);
    repeat (W + 2) begin
      @(posedge clk); #1;
      chk("abort no out_valid", out_valid, 0);
    end
    run_op(OP_MUL, 13, 11, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
